apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB initiator that converts a single-outstanding valid/ready request/response interface into APB4 SETUP/ACCESS transfers.
- Lets a simple core-side agent or bench drive APB peripherals (GPIO, UART, etc.) on the peripheral bus.
- Exactly one transfer is in flight at a time. The bridge returns read data and the error flag through a response handshake.

Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width (multiple of 8)
- TIMEOUT_CYCLES, 255, max ACCESS-phase cycles waiting for pready (used only with APB_MASTER_TIMEOUT_EN)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge accepts request
- req_addr  in  ADDR_W  transfer address
- req_write  in  1  1=write, 0=read
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  write byte strobes
- req_prot  in  3  APB pprot value
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  DATA_W  read data (0 for writes)
- resp_err  out  1  pslverr or timeout
- out_paddr  out  ADDR_W  APB address
- out_psel  out  1  APB select
- out_penable  out  1  APB enable
- out_pprot  out  3  APB protection
- out_pwrite  out  1  APB direction
- out_pwdata  out  DATA_W  APB write data
- out_pstrb  out  DATA_W/8  APB strobes
- out_pready  in  1  APB ready
- out_prdata  in  DATA_W  APB read data
- out_pslverr  in  1  APB error

Behaviour:
- Clock is `clock`. Reset is `reset_n`: synchronous and active-low. All state is cleared on the clock edge where reset_n=0.
- Reset values:
  - FSM=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
  - out_psel=0; out_penable=0; out_paddr=0; out_pwrite=0; out_pwdata=0; out_pstrb=0; out_pprot=0.
- FSM states are IDLE, SETUP, ACCESS, RESP. All outputs are registered except req_ready, which equals (state==IDLE).
- IDLE:
  - On req_valid&req_ready, capture addr/write/wdata/prot into the APB output registers and go to SETUP.
  - out_pstrb = req_wstrb for a write, 0 for a read (APB4 rule).
- SETUP (one cycle): psel=1, penable=0. Next state is ACCESS.
- ACCESS: psel=1, penable=1. APB signals are held stable until pready.
  - On out_pready=1: latch resp_rdata = (write ? 0 : out_prdata) and resp_err = out_pslverr.
  - Same edge: drop psel/penable and go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_valid&resp_ready, go to IDLE and clear resp_valid.
- Latency: request accepted at edge T; SETUP in cycle T+1; ACCESS in cycle T+2. If pready=1 in T+2, resp_valid is asserted in T+3 (minimum 3 cycles). Each pready wait state adds 1 cycle.
- Back-to-back: a new request can be accepted the cycle after the resp handshake (IDLE), so there are at least 4 cycles between successive request acceptances.
- A request presented while busy is not accepted; req_ready=0 and the requester must hold it.
- pready or pslverr seen outside ACCESS is ignored.
- Reset mid-transfer: psel/penable drop the same edge, any pending response is discarded, and the FSM returns to IDLE.
- pwdata/paddr/pstrb keep their last values in IDLE; only psel qualifies them.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro:
  - An 8+ bit wait counter clears on entering ACCESS and increments each ACCESS cycle without pready.
  - When the count reaches TIMEOUT_CYCLES without pready: abort (psel/penable=0), go to RESP with resp_err=1 and resp_rdata=0.
  - If pready arrives in the same cycle the count reaches TIMEOUT_CYCLES, pready wins and the normal response is returned.
- Without the macro: no counter; ACCESS waits indefinitely for pready.

Test Plan:
- Write with zero wait states:
  - Stimulus: req addr=0x10002000, wdata=0x0000A5A5, wstrb=0x3, write=1; pready tied 1.
  - Required: psel=1/penable=0 in T+1; penable=1 with pstrb=0x3 in T+2; resp_valid in T+3 with resp_rdata=0, resp_err=0.
- Read with 3 wait states:
  - Stimulus: addr=0x10002004, write=0; slave holds pready=0 for 3 cycles, then pready=1 with prdata=0x00001234.
  - Required: pstrb=0 throughout; APB signals stable during waits; resp_rdata=0x00001234 arrives 6 cycles after acceptance.
- Slave error:
  - Stimulus: write with pslverr=1 together with pready.
  - Required: resp_err=1.
  - Then hold resp_ready=0 for 5 cycles: resp_valid, resp_err and resp_rdata stay stable and req_ready stays 0.
- Back-to-back:
  - Stimulus: two requests offered continuously, resp_ready=1.
  - Required: second acceptance exactly 4 cycles after the first; the two transfers do not overlap on psel.
- Reset mid-ACCESS:
  - Stimulus: reset_n=0 for 1 cycle while pready=0.
  - Required: next cycle psel=0, penable=0, resp_valid=0, req_ready=1.
- Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: pready held 0.
  - Required: abort after 4 ACCESS cycles; resp_err=1 and resp_rdata=0.
  - Without the macro, the same stimulus keeps psel=1 for 100+ cycles.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Request/response and APB4 bus bundle for apb_master_bridge.
// master: the bridge side. slave: the requester plus APB peripheral side.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_write;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic [2:0]            req_prot;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  logic [ADDR_W-1:0]     out_paddr;
  logic                  out_psel;
  logic                  out_penable;
  logic [2:0]            out_pprot;
  logic                  out_pwrite;
  logic [DATA_W-1:0]     out_pwdata;
  logic [DATA_W/8-1:0]   out_pstrb;
  logic                  out_pready;
  logic [DATA_W-1:0]     out_prdata;
  logic                  out_pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    input  resp_ready,
    input  out_pready, out_prdata, out_pslverr,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output out_paddr, out_psel, out_penable, out_pprot, out_pwrite,
    output out_pwdata, out_pstrb
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    output resp_ready,
    output out_pready, out_prdata, out_pslverr,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite,
    input  out_pwdata, out_pstrb
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB4 initiator.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN;
// without it the bridge waits for pready indefinitely.
//
// state  | meaning
// IDLE   | ready for a request, APB idle (address/data keep last values)
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1, waiting for pready
// RESP   | resp_valid=1, holding rdata/err until resp_ready
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clock,
  input logic               reset_n,
  apb_master_bridge_if.master bus
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state;
  logic                psel;
  logic                penable;
  logic [ADDR_W-1:0]   paddr;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [STRB_W-1:0]   pstrb;
  logic [2:0]          pprot;
  logic                resp_valid;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;

`ifdef APB_MASTER_TIMEOUT_EN
  // At least 8 bits, wider if the limit needs it.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]    wait_cnt;
`endif

  // Transfer sequencer; every bus-facing output except req_ready is a register here.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      pstrb      <= '0;
      pprot      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            paddr  <= bus.req_addr;
            pwrite <= bus.req_write;
            pwdata <= bus.req_wdata;
            pprot  <= bus.req_prot;
            // Reads never carry strobes on APB4.
            pstrb  <= bus.req_write ? bus.req_wstrb : '0;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          // pready is checked first so it wins over a coincident timeout.
          if (bus.out_pready) begin
            resp_rdata <= pwrite ? '0 : bus.out_prdata;
            resp_err   <= bus.out_pslverr;
            psel       <= 1'b0;
            penable    <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            psel       <= 1'b0;
            penable    <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output wiring; req_ready is the only combinational output.
  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_rdata  = resp_rdata;
  assign bus.resp_err    = resp_err;
  assign bus.out_psel    = psel;
  assign bus.out_penable = penable;
  assign bus.out_paddr   = paddr;
  assign bus.out_pwrite  = pwrite;
  assign bus.out_pwdata  = pwdata;
  assign bus.out_pstrb   = pstrb;
  assign bus.out_pprot   = pprot;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: table vectors, hand sequences
// for back-to-back / reset / timeout, and randomized transfers.
module tb_apb_master_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [2:0]    prot;
    int            waits;
    logic [DW-1:0] slv_rdata;
    logic          slv_err;
    int            hold;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference: response data and error follow directly from the request and slave reply.
  task automatic model(inout vec_t v);
    v.exp_rdata = v.write ? '0 : v.slv_rdata;
    v.exp_err   = v.slv_err;
  endtask

  task automatic check_apb(input string tag, input vec_t v, input logic en);
    logic [SW-1:0] exp_strb;
    exp_strb = v.write ? v.wstrb : '0;
    check({tag, " psel"},    64'(bus.out_psel), 64'(1'b1));
    check({tag, " penable"}, 64'(bus.out_penable), 64'(en));
    check({tag, " paddr"},   64'(bus.out_paddr), 64'(v.addr));
    check({tag, " pwrite"},  64'(bus.out_pwrite), 64'(v.write));
    check({tag, " pwdata"},  64'(bus.out_pwdata), 64'(v.wdata));
    check({tag, " pstrb"},   64'(bus.out_pstrb), 64'(exp_strb));
    check({tag, " pprot"},   64'(bus.out_pprot), 64'(v.prot));
    check({tag, " req_ready busy"}, 64'(bus.req_ready), 64'(1'b0));
    check({tag, " resp_valid early"}, 64'(bus.resp_valid), 64'(1'b0));
  endtask

  // Runs one complete transfer; called at a negedge with the bridge idle.
  task automatic run_vec(input vec_t v, input string tag);
    bus.req_valid  = 1'b1;
    bus.req_addr   = v.addr;
    bus.req_write  = v.write;
    bus.req_wdata  = v.wdata;
    bus.req_wstrb  = v.wstrb;
    bus.req_prot   = v.prot;
    bus.resp_ready = 1'b0;
    bus.out_pready = 1'($urandom);
    check({tag, " req_ready idle"}, 64'(bus.req_ready), 64'(1'b1));
    step();
    // Scramble request fields: the bridge must have captured them already.
    bus.req_valid  = 1'b0;
    bus.req_addr   = AW'($urandom);
    bus.req_wdata  = DW'($urandom);
    bus.req_wstrb  = SW'($urandom);
    bus.req_prot   = 3'($urandom);
    bus.req_write  = 1'($urandom);
    check_apb({tag, " setup"}, v, 1'b0);
    bus.out_pready  = 1'($urandom);
    bus.out_pslverr = 1'($urandom);
    bus.out_prdata  = DW'($urandom);
    step();
    for (int i = 0; i <= v.waits; i++) begin
      check_apb({tag, " access"}, v, 1'b1);
      bus.out_pready  = (i == v.waits);
      bus.out_prdata  = (i == v.waits) ? v.slv_rdata : DW'($urandom);
      bus.out_pslverr = (i == v.waits) ? v.slv_err : 1'($urandom);
      step();
    end
    bus.out_pready  = 1'($urandom);
    bus.out_prdata  = DW'($urandom);
    bus.out_pslverr = 1'($urandom);
    check({tag, " resp_valid"}, 64'(bus.resp_valid), 64'(1'b1));
    check({tag, " resp_rdata"}, 64'(bus.resp_rdata), 64'(v.exp_rdata));
    check({tag, " resp_err"},   64'(bus.resp_err), 64'(v.exp_err));
    check({tag, " psel off"},   64'({bus.out_psel, bus.out_penable}), 64'(2'b00));
    check({tag, " req_ready resp"}, 64'(bus.req_ready), 64'(1'b0));
    for (int h = 0; h < v.hold; h++) begin
      step();
      bus.out_pready = 1'($urandom);
      check({tag, " hold valid"}, 64'(bus.resp_valid), 64'(1'b1));
      check({tag, " hold rdata"}, 64'(bus.resp_rdata), 64'(v.exp_rdata));
      check({tag, " hold err"},   64'(bus.resp_err), 64'(v.exp_err));
      check({tag, " hold req_ready"}, 64'(bus.req_ready), 64'(1'b0));
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    bus.out_pready = 1'b0;
    check({tag, " done valid"}, 64'(bus.resp_valid), 64'(1'b0));
    check({tag, " done req_ready"}, 64'(bus.req_ready), 64'(1'b1));
  endtask

  vec_t tbl[5];
  int   acc[$];
  int   cnt;

  initial begin
    bus.req_valid = 1'b1; bus.req_addr = 32'h1234_5678; bus.req_write = 1'b1;
    bus.req_wdata = 32'hFFFF_FFFF; bus.req_wstrb = 4'hF; bus.req_prot = 3'h7;
    bus.resp_ready = 1'b0; bus.out_pready = 1'b1; bus.out_prdata = 32'h0;
    bus.out_pslverr = 1'b0;

    // Reset state (req_valid high must not matter while in reset)
    repeat (2) step();
    check("rst req_ready", 64'(bus.req_ready), 64'(1'b1));
    check("rst resp_valid", 64'(bus.resp_valid), 64'(1'b0));
    check("rst resp_rdata", 64'(bus.resp_rdata), 64'(0));
    check("rst resp_err", 64'(bus.resp_err), 64'(1'b0));
    check("rst psel/penable", 64'({bus.out_psel, bus.out_penable}), 64'(2'b00));
    check("rst paddr", 64'(bus.out_paddr), 64'(0));
    check("rst pwdata", 64'(bus.out_pwdata), 64'(0));
    check("rst pstrb/pwrite/pprot", 64'({bus.out_pstrb, bus.out_pwrite, bus.out_pprot}), 64'(0));
    bus.req_valid = 1'b0;
    bus.out_pready = 1'b0;
    reset_n = 1'b1;
    step();

    // addr, write, wdata, wstrb, prot, waits, slv_rdata, slv_err, hold, exp_rdata, exp_err
    tbl[0] = '{32'h1000_2000, 1'b1, 32'h0000_A5A5, 4'h3, 3'h0, 0, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, 1'b0};
    tbl[1] = '{32'h1000_2004, 1'b0, 32'h5555_0000, 4'hF, 3'h1, 3, 32'h0000_1234, 1'b0, 1, 32'h0000_1234, 1'b0};
    tbl[2] = '{32'h1000_2008, 1'b1, 32'h1122_3344, 4'hF, 3'h2, 1, 32'hCAFE_F00D, 1'b1, 5, 32'h0, 1'b1};
    tbl[3] = '{32'h1000_200C, 1'b0, 32'h0, 4'h9, 3'h5, 0, 32'h0BAD_F00D, 1'b1, 0, 32'h0BAD_F00D, 1'b1};
    tbl[4] = '{32'hFFFF_FFFC, 1'b1, 32'h8000_0001, 4'h8, 3'h7, 2, 32'h7777_7777, 1'b0, 2, 32'h0, 1'b0};
    for (int k = 0; k < 5; k++) run_vec(tbl[k], $sformatf("tbl%0d", k));

    // Back-to-back: request held, pready and resp_ready tied high
    bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0020; bus.req_write = 1'b1;
    bus.req_wdata = 32'h0000_00AA; bus.req_wstrb = 4'h1; bus.req_prot = 3'h0;
    bus.resp_ready = 1'b1; bus.out_pready = 1'b1; bus.out_pslverr = 1'b0;
    acc.delete();
    for (int c = 0; c < 12; c++) begin
      if (bus.req_ready) begin
        acc.push_back(c);
        check("b2b psel at accept", 64'(bus.out_psel), 64'(1'b0));
      end
      step();
    end
    bus.req_valid = 1'b0;
    check("b2b accept count", 64'(acc.size()), 64'(3));
    if (acc.size() >= 3) begin
      check("b2b spacing 1", 64'(acc[1] - acc[0]), 64'(4));
      check("b2b spacing 2", 64'(acc[2] - acc[1]), 64'(4));
    end
    repeat (4) step();
    bus.resp_ready = 1'b0; bus.out_pready = 1'b0;
    check("b2b drained", 64'(bus.req_ready), 64'(1'b1));

    // Reset mid-ACCESS
    bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0030; bus.req_write = 1'b0;
    step();
    bus.req_valid = 1'b0;
    step();
    check("rma in access", 64'({bus.out_psel, bus.out_penable}), 64'(2'b11));
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rma psel/penable", 64'({bus.out_psel, bus.out_penable}), 64'(2'b00));
    check("rma resp_valid", 64'(bus.resp_valid), 64'(1'b0));
    check("rma req_ready", 64'(bus.req_ready), 64'(1'b1));
    check("rma paddr", 64'(bus.out_paddr), 64'(0));
    bus.out_pready = 1'b1;
    step();
    check("rma no resp", 64'(bus.resp_valid), 64'(1'b0));
    bus.out_pready = 1'b0;

    // Stalled slave: pready held low
    bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0040; bus.req_write = 1'b0;
    bus.out_prdata = 32'h5A5A_5A5A; bus.out_pslverr = 1'b0;
    step();
    bus.req_valid = 1'b0;
    step();
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      check("tmo access", 64'({bus.out_psel, bus.out_penable, bus.resp_valid}), 64'(3'b110));
      step();
    end
    check("tmo resp_valid", 64'(bus.resp_valid), 64'(1'b1));
    check("tmo resp_err", 64'(bus.resp_err), 64'(1'b1));
    check("tmo resp_rdata", 64'(bus.resp_rdata), 64'(0));
    check("tmo psel", 64'({bus.out_psel, bus.out_penable}), 64'(2'b00));
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("tmo idle", 64'(bus.req_ready), 64'(1'b1));
`else
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      if (bus.out_psel && bus.out_penable && !bus.resp_valid) cnt++;
      step();
    end
    check("stall access cycles", 64'(cnt), 64'(120));
    check("stall psel", 64'(bus.out_psel), 64'(1'b1));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("stall recover", 64'(bus.req_ready), 64'(1'b1));
`endif

    // Randomized transfers against the reference
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.addr      = AW'($urandom);
      v.write     = 1'($urandom);
      v.wdata     = DW'($urandom);
      v.wstrb     = SW'($urandom);
      v.prot      = 3'($urandom);
      v.waits     = int'($urandom_range(0, 3));
      v.slv_rdata = DW'($urandom);
      v.slv_err   = ($urandom_range(0, 3) == 0);
      v.hold      = int'($urandom_range(0, 2));
      model(v);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
